// File: rtl/encoder_scan_sched.sv
// Shared sampling scheduler for the rotary-encoder peripheral.
// One programmable period counter (period = (cmp << 6) + 1 clocks) triggers
// a round-robin scan that issues one-cycle sample enables, one channel per
// cycle, to up to CHANNELS encoder decoders.
module encoder_scan_sched #(
    parameter int WIDTH    = 16,  // period counter width, >= 14
    parameter int CHANNELS = 4    // scanned channels, 1..64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          cmp_in,
    input  logic                cmp_load,
    input  logic [CHANNELS-1:0] chan_en,
    output logic [CHANNELS-1:0] sample_en,
    output logic                scan_active,
    output logic                frame_done,
    output logic [7:0]          cmp_active
);

    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(CHANNELS - 1);
    localparam logic [CHANNELS-1:0] ONE_HOT0 = CHANNELS'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t              state_q,       state_d;
    logic [WIDTH-1:0]    count_q,       count_d;
    logic [7:0]          cmp_active_q,  cmp_active_d;
    logic [7:0]          pend_q,        pend_d;
    logic                pend_valid_q,  pend_valid_d;
    logic [IDX_W-1:0]    idx_q,         idx_d;
    logic [CHANNELS-1:0] mask_q,        mask_d;
    logic [CHANNELS-1:0] sample_en_q,   sample_en_d;
    logic                scan_active_q, scan_active_d;
    logic                frame_done_q,  frame_done_d;

    logic [WIDTH-1:0] limit;
    logic             tick;
    logic [IDX_W-1:0] idx_next;

    // Limit is cmp_active shifted up by six; the tick fires when count reaches it.
    assign limit    = {{(WIDTH-8){1'b0}}, cmp_active_q} << 6;
    assign tick     = (state_q == WAIT) && (count_q >= limit);
    assign idx_next = idx_q + 1'b1;

    // Next-state, counter, compare bookkeeping and next registered strobes.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which is what would otherwise infer a latch.
        state_d       = state_q;
        count_d       = count_q;
        cmp_active_d  = cmp_active_q;
        pend_d        = pend_q;
        pend_valid_d  = pend_valid_q;
        idx_d         = idx_q;
        mask_d        = mask_q;
        sample_en_d   = '0;
        scan_active_d = 1'b0;
        frame_done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                count_d = '0;
                if (cmp_load && (cmp_in != 8'd0)) begin
                    cmp_active_d = cmp_in;
                    pend_valid_d = 1'b0;
                    state_d      = WAIT;
                end
            end

            WAIT: begin
                if (tick) begin
                    count_d       = '0;
                    mask_d        = chan_en;
                    idx_d         = '0;
                    state_d       = SCAN;
                    sample_en_d   = chan_en & ONE_HOT0;
                    scan_active_d = 1'b1;
                    frame_done_d  = (CHANNELS == 1);
                    // A load on the tick cycle beats any older pending value.
                    if (cmp_load) begin
                        cmp_active_d = cmp_in;
                    end else if (pend_valid_q) begin
                        cmp_active_d = pend_q;
                    end
                    pend_valid_d = 1'b0;
                end else begin
                    count_d = count_q + 1'b1;
                    if (cmp_load) begin
                        pend_d       = cmp_in;
                        pend_valid_d = 1'b1;
                    end
                end
            end

            SCAN: begin
                // The counter keeps running so tick spacing stays limit+1.
                count_d = count_q + 1'b1;
                if (cmp_load) begin
                    pend_d       = cmp_in;
                    pend_valid_d = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    if (cmp_active_q == 8'd0) begin
                        state_d = IDLE;
                        count_d = '0;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    idx_d         = idx_next;
                    sample_en_d   = (ONE_HOT0 << idx_next) & mask_q;
                    scan_active_d = 1'b1;
                    frame_done_d  = (idx_next == LAST_IDX);
                end
            end

            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q       <= IDLE;
            count_q       <= '0;
            cmp_active_q  <= '0;
            pend_q        <= '0;
            pend_valid_q  <= 1'b0;
            idx_q         <= '0;
            mask_q        <= '0;
            sample_en_q   <= '0;
            scan_active_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            cmp_active_q  <= cmp_active_d;
            pend_q        <= pend_d;
            pend_valid_q  <= pend_valid_d;
            idx_q         <= idx_d;
            mask_q        <= mask_d;
            sample_en_q   <= sample_en_d;
            scan_active_q <= scan_active_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign sample_en   = sample_en_q;
    assign scan_active = scan_active_q;
    assign frame_done  = frame_done_q;
    assign cmp_active  = cmp_active_q;

endmodule

// File: tb/tb_encoder_scan_sched.sv
// Directed testbench for encoder_scan_sched (WIDTH=16, CHANNELS=4).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_encoder_scan_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] cmp_in;
    logic       cmp_load;
    logic [3:0] chan_en;
    logic [3:0] sample_en;
    logic       scan_active;
    logic       frame_done;
    logic [7:0] cmp_active;

    int n_checks = 0;
    int n_fails  = 0;

    encoder_scan_sched #(.WIDTH(16), .CHANNELS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmp_in     (cmp_in),
        .cmp_load   (cmp_load),
        .chan_en    (chan_en),
        .sample_en  (sample_en),
        .scan_active(scan_active),
        .frame_done (frame_done),
        .cmp_active (cmp_active)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle cmp_load pulse; returns in the following cycle.
    task automatic load(input logic [7:0] v);
        cmp_in   = v;
        cmp_load = 1'b1;
        step(1);
        cmp_load = 1'b0;
    endtask

    // Step until scan_active rises (bounded) and compare the step count.
    task automatic run_to_scan(input string tag, input int exp_steps);
        int n;
        n = 0;
        while (scan_active !== 1'b1 && n < 1000) begin
            step(1);
            n++;
        end
        chk(tag, n, exp_steps);
    endtask

    // Entered on the first scan cycle; checks all four slots and the exit cycle.
    task automatic check_scan(input string tag, input logic [3:0] mask);
        logic [3:0] oh;
        for (int k = 0; k < 4; k++) begin
            oh = 4'b0001 << k;
            chk({tag, "_sample"}, sample_en, oh & mask);
            chk({tag, "_active"}, scan_active, 1'b1);
            chk({tag, "_done"}, frame_done, (k == 3) ? 1'b1 : 1'b0);
            step(1);
        end
        chk({tag, "_exit_active"}, scan_active, 1'b0);
        chk({tag, "_exit_sample"}, sample_en, 4'b0000);
    endtask

    initial begin
        int quiet_bad;
        reset    = 1'b1;
        cmp_in   = 8'd0;
        cmp_load = 1'b0;
        chan_en  = 4'b1111;
        step(2);
        chk("rst_sample", sample_en, 4'b0000);
        chk("rst_active", scan_active, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_cmp", cmp_active, 8'd0);
        reset = 1'b0;
        step(1);

        // 1: cmp=1 from IDLE, first scan 65 cycles after the load.
        load(8'd1);                       // now in L+1
        chk("t1_cmp", cmp_active, 8'd1);
        step(63);                         // L+64
        chk("t1_pre_active", scan_active, 1'b0);
        step(1);                          // L+65 tick cycle
        chk("t1_tick_sample", sample_en, 4'b0000);
        step(1);                          // L+66
        check_scan("t1_scan0", 4'b1111);  // ends at L+70
        run_to_scan("t1_spacing", 61);    // L+131
        check_scan("t1_scan1", 4'b1111);

        // 2: cmp=2, mask 0101, 129-cycle spacing.
        chan_en = 4'b0101;
        load(8'd2);
        run_to_scan("t2_first", 60);
        chk("t2_cmp", cmp_active, 8'd2);
        check_scan("t2_scan0", 4'b0101);
        run_to_scan("t2_spacing", 125);
        check_scan("t2_scan1", 4'b0101);

        // 3: back to cmp=1, then 3 and 2 mid-period; last pending wins at the tick.
        load(8'd1);
        run_to_scan("t3_to1", 124);
        chk("t3_cmp1", cmp_active, 8'd1);
        check_scan("t3_scan_a", 4'b0101);
        step(10);
        load(8'd3);
        step(20);
        load(8'd2);
        run_to_scan("t3_period_kept", 29);
        chk("t3_cmp2", cmp_active, 8'd2);
        check_scan("t3_scan_b", 4'b0101);
        run_to_scan("t3_new_spacing", 125);
        check_scan("t3_scan_c", 4'b0101);
        // Pending 5, then a load of 1 on the exact tick cycle.
        load(8'd5);
        step(123);
        chk("t3_tick_pre", scan_active, 1'b0);
        load(8'd1);
        chk("t3_tick_load", cmp_active, 8'd1);
        check_scan("t3_scan_d", 4'b0101);
        run_to_scan("t3_tick_spacing", 61);
        check_scan("t3_scan_e", 4'b0101);

        // 4: load 0 while running: one more full scan, then IDLE.
        chan_en = 4'b1111;
        load(8'd0);
        run_to_scan("t4_last", 60);
        chk("t4_cmp0", cmp_active, 8'd0);
        check_scan("t4_scan", 4'b1111);
        quiet_bad = 0;
        for (int i = 0; i < 520; i++) begin
            if (sample_en !== 4'b0000 || scan_active !== 1'b0) quiet_bad++;
            step(1);
        end
        chk("t4_idle_quiet", quiet_bad, 0);
        load(8'd1);
        run_to_scan("t4_restart", 65);
        check_scan("t4_scan_restart", 4'b1111);

        // 5: chan_en dropped mid-scan only affects the next scan.
        run_to_scan("t5_first", 61);
        chk("t5_s0", sample_en, 4'b0001);
        step(1);
        chan_en = 4'b0000;
        chk("t5_s1", sample_en, 4'b0010);
        step(1);
        chk("t5_s2", sample_en, 4'b0100);
        step(1);
        chk("t5_s3", sample_en, 4'b1000);
        chk("t5_s3_done", frame_done, 1'b1);
        step(1);
        run_to_scan("t5_second", 61);
        check_scan("t5_silent", 4'b0000);

        // 6: reset in the second scan cycle aborts immediately.
        chan_en = 4'b1111;
        run_to_scan("t6_scan", 61);
        step(1);                          // T+2
        reset = 1'b1;
        step(1);                          // T+3
        chk("t6_sample", sample_en, 4'b0000);
        chk("t6_active", scan_active, 1'b0);
        chk("t6_done", frame_done, 1'b0);
        chk("t6_cmp", cmp_active, 8'd0);
        reset = 1'b0;
        load(8'd0);                       // ignored in IDLE
        quiet_bad = 0;
        for (int i = 0; i < 200; i++) begin
            if (sample_en !== 4'b0000 || scan_active !== 1'b0 || cmp_active !== 8'd0)
                quiet_bad++;
            step(1);
        end
        chk("t6_idle_quiet", quiet_bad, 0);
        load(8'd1);
        run_to_scan("t6_restart", 65);
        check_scan("t6_scan_restart", 4'b1111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/encoder_scan_sched.md
Name: encoder_scan_sched

Overview:
Shared sampling scheduler for the rotary-encoder peripheral. It owns one programmable period counter, with period = (cmp << 6) + 1 clocks. On each period tick it runs a round-robin scan that issues one-cycle sample enables to up to CHANNELS encoder decoders, one channel per cycle. It sits between the peripheral register block (cmp writes, channel enable mask) and the per-channel quadrature/debounce logic, and replaces the per-channel strobe generators.

Parameters:
WIDTH, 16, period counter width; must be >= 14 so that cmp << 6 fits.
CHANNELS, 4, number of encoder channels scanned; legal range 1..64, so a tick can never land inside a scan.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cmp_in  in  8  new period compare value
cmp_load  in  1  one-cycle pulse; latch cmp_in
chan_en  in  CHANNELS  per-channel scan enable mask
sample_en  out  CHANNELS  registered one-hot sample strobe; 0 or 1 bit set per cycle
scan_active  out  1  high for every cycle of a scan
frame_done  out  1  one-cycle pulse on the last scan cycle
cmp_active  out  8  compare value currently in use

Behaviour:
- Reset (synchronous, checked first, overrides everything). State = IDLE. count, cmp_active, pending value, pend_valid, scan index and scan mask all = 0. sample_en, scan_active and frame_done = 0.
- Limit arithmetic. limit = {cmp_active, 6'b0}, zero-extended to WIDTH. Tick condition: state WAIT and count >= limit.
- State IDLE (cmp_active == 0):
  - count is held at 0; no ticks are generated.
  - A cmp_load with cmp_in != 0 at cycle L sets cmp_active = cmp_in and count = 0 in L+1, and state becomes WAIT.
  - A cmp_load with cmp_in == 0 has no effect.
- State WAIT:
  - count increments by 1 per cycle.
  - On a tick at cycle T:
    - count <= 0.
    - scan mask <= chan_en sampled at T.
    - index <= 0.
    - state <= SCAN.
    - If cmp_load is high at T, cmp_active <= cmp_in. Otherwise, if pend_valid, cmp_active <= pending value. pend_valid is cleared in both cases.
- State SCAN:
  - Lasts exactly CHANNELS cycles, T+1 .. T+CHANNELS. In cycle T+1+k, sample_en = one-hot(k) AND scan mask.
  - Masked channels produce a silent slot; the scan length does not change.
  - scan_active = 1 throughout the scan. frame_done = 1 only in cycle T+CHANNELS.
  - count keeps running from 0 during the scan, so tick-to-tick spacing is exactly limit+1 cycles.
  - On exit: state <= IDLE if cmp_active == 0 (count forced to 0), else state <= WAIT.
- cmp_load outside IDLE and not coincident with a tick: pending <= cmp_in, pend_valid <= 1. A later load overwrites the pending value; the last write wins.
- The period never changes mid-period; a new value takes effect only at a tick.
- Loading 0 while running: the next tick still performs its scan (with the old mask), then the block goes to IDLE.
- chan_en changes during a scan are ignored until the next tick's snapshot.
- An all-zero mask still produces a full scan: scan_active and frame_done assert, sample_en stays 0.
- Reset mid-scan aborts the scan immediately; the next cycle shows all outputs at their reset values.
- sample_en, scan_active and frame_done are driven from registers; there are no combinational paths from inputs to outputs.

Test Plan:
1. Reset, then cmp_load=1 with cmp_in=1 at cycle L, chan_en=4'b1111 -> cmp_active=1 at L+1. First tick at L+65; sample_en = 0001, 0010, 0100, 1000 in cycles L+66..L+69. frame_done at L+69. Next sample_en[0] at L+131.
2. cmp=2, chan_en=4'b0101 -> sample_en = 0001, 0000, 0100, 0000 per scan; scan_active high for 4 cycles; frame_done high on the 4th; tick spacing 129 cycles.
3. Running with cmp=1; load 3 mid-period, then 2 before the tick -> the current period stays 65 cycles, cmp_active=2 after the tick, following periods are 129 cycles. Load on the exact tick cycle -> that cmp_in wins over the pending value.
4. Running; load cmp_in=0 -> the next tick still scans all channels, then IDLE. sample_en stays 0 for 500+ cycles. Reloading 1 restarts with the first tick 65 cycles after the load.
5. Toggle chan_en mid-scan from 1111 to 0000 -> the current scan completes with all four strobes. The next scan has a silent sample_en but scan_active and frame_done still assert.
6. Assert reset during SCAN cycle T+2 -> all outputs 0 on the next cycle, cmp_active=0, IDLE; no further strobes until a new cmp_load.
